// File: rtl/ledger_pkg.sv
`default_nettype none
// ============================================================================
// ledger_pkg: shared ledger geometry, output tags, reader FSM states.
// Rev 1.0
// ============================================================================
package ledger_pkg;

  localparam int MEM_WIDTH = 72;
  localparam int MEM_DEPTH = 16384;
  localparam int ID_W      = 48;
  localparam int BAL_W     = 24;
  localparam int WORD_W    = 128;

  localparam logic [7:0] TAG_DUMP_REC    = 8'hA1;
  localparam logic [7:0] TAG_DUMP_END    = 8'hAF;
  localparam logic [7:0] TAG_LOOKUP_HIT  = 8'hA2;
  localparam logic [7:0] TAG_LOOKUP_MISS = 8'hAE;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Result word: tag | index | 32 reserved zero bits | ledger entry
  function automatic logic [WORD_W-1:0] pack_word(input logic [7:0]            tag,
                                                  input logic [15:0]           index,
                                                  input logic [ID_W+BAL_W-1:0] entry);
    return {tag, index, 32'h0, entry};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ledger_out_reg.sv
`default_nettype none
// ============================================================================
// ledger_out_reg: single-entry valid/ready output register.
// Rev 1.0
// ============================================================================
module ledger_out_reg #(
  parameter int W = ledger_pkg::WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  // A push may coincide with the drain of the current word; the push wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (push) begin
      data_o  <= push_data;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ledger_reader.sv
`default_nettype none
// ============================================================================
// ledger_reader: dumps the ledger or looks up one id over an arbitrated port.
// Rev 1.0
// ============================================================================
module ledger_reader #(
  parameter  int MEM_WIDTH = ledger_pkg::MEM_WIDTH,
  parameter  int MEM_DEPTH = ledger_pkg::MEM_DEPTH,
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_op,
  input  logic [ledger_pkg::ID_W-1:0] cmd_id,
  input  logic [AW:0]                 entry_count,
  output logic                        mem_rd_req,
  input  logic                        mem_rd_gnt,
  output logic [AW-1:0]               mem_rd_addr,
  input  logic [MEM_WIDTH-1:0]        mem_rd_data,
  output logic [ledger_pkg::WORD_W-1:0] data_o,
  output logic                        valid_o,
  input  logic                        ready_i
);
  import ledger_pkg::*;

  localparam logic [AW:0] DEPTH_N = (AW+1)'(MEM_DEPTH);

  state_t            state;
  logic              op_q;
  logic [ID_W-1:0]   id_q;
  logic [AW:0]       n_q;
  logic [AW:0]       idx;
  logic [AW:0]       idx_inc;
  logic [AW:0]       n_in;
  logic              hit;
  logic              push;
  logic [WORD_W-1:0] push_data;

  assign n_in    = (entry_count > DEPTH_N) ? DEPTH_N : entry_count;
  assign idx_inc = idx + 1'b1;
  assign hit     = (mem_rd_data[MEM_WIDTH-1 -: ID_W] == id_q);

  assign mem_rd_req  = (state == RD_REQ);
  assign mem_rd_addr = mem_rd_req ? idx[AW-1:0] : '0;

  function automatic logic [WORD_W-1:0] term_word(input logic            op,
                                                  input logic [AW:0]     n,
                                                  input logic [ID_W-1:0] id);
    return op ? pack_word(TAG_LOOKUP_MISS, 16'(n), {id, {BAL_W{1'b0}}})
              : pack_word(TAG_DUMP_END, 16'(n), '0);
  endfunction

  // Words are pushed on the same edge as the matching FSM transition so the
  // record appears three cycles after the command is accepted.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready && (n_in == '0)) begin
          push      = 1'b1;
          push_data = term_word(cmd_op, '0, cmd_id);
        end
      end
      RD_WAIT: begin
        if (!op_q || hit) begin
          push      = 1'b1;
          push_data = pack_word(op_q ? TAG_LOOKUP_HIT : TAG_DUMP_REC, 16'(idx), mem_rd_data);
        end else if (idx_inc == n_q) begin
          push      = 1'b1;
          push_data = term_word(op_q, n_q, id_q);
        end
      end
      EMIT: begin
        if (ready_i && !op_q && (idx_inc == n_q)) begin
          push      = 1'b1;
          push_data = term_word(op_q, n_q, id_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      op_q      <= 1'b0;
      id_q      <= '0;
      n_q       <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            id_q      <= cmd_id;
            n_q       <= n_in;
            idx       <= '0;
            cmd_ready <= 1'b0;
            state     <= (n_in == '0) ? DONE : RD_REQ;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RD_REQ: begin
          if (mem_rd_gnt) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (!op_q || hit) begin
            state <= EMIT;
          end else begin
            idx   <= idx_inc;
            state <= (idx_inc == n_q) ? DONE : RD_REQ;
          end
        end
        EMIT: begin
          if (ready_i) begin
            if (op_q) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end else begin
              idx   <= idx_inc;
              state <= (idx_inc == n_q) ? DONE : RD_REQ;
            end
          end
        end
        DONE: begin
          if (valid_o && ready_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ledger_out_reg #(.W(WORD_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .valid_o   (valid_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_ledger_reader.sv
`default_nettype none
// ============================================================================
// tb_ledger_reader: directed and randomized checks against a ledger model.
// Rev 1.0
// ============================================================================
module tb_ledger_reader;
  import ledger_pkg::*;

  localparam int AW = $clog2(MEM_DEPTH);

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_op = 1'b0;
  logic [47:0]  cmd_id = '0;
  logic [AW:0]  entry_count = '0;
  logic         mem_rd_req;
  logic         mem_rd_gnt;
  logic [AW-1:0] mem_rd_addr;
  logic [71:0]  mem_rd_data;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ready_i;

  ledger_reader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_id(cmd_id),
    .entry_count(entry_count),
    .mem_rd_req(mem_rd_req), .mem_rd_gnt(mem_rd_gnt), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  logic [71:0] mem [MEM_DEPTH];

  // Ledger RAM behind the arbiter: data one cycle after a granted request,
  // junk otherwise so a mistimed capture is visible.
  always @(posedge clk)
    mem_rd_data <= (mem_rd_req && mem_rd_gnt) ? mem[mem_rd_addr] : 72'({$urandom(), $urandom(), $urandom()});

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int           drv_mode = 0;  // 0 always ready/granted, 1 random, 2 forced
  logic         gnt_f = 1'b1;
  logic         rdy_f = 1'b1;
  logic [127:0] got_q[$];
  logic [127:0] exp_q[$];
  int           rd_q[$];
  int           exp_rd[$];
  int           cyc = 0, acc_cyc = -1, first_v = -1, req_seen = 0, stall_o = 0, stall_r = 0;
  logic         prev_so = 1'b0, prev_sr = 1'b0;
  logic [127:0] prev_data = '0;
  logic [AW-1:0] prev_addr = '0;

  task automatic drive_step();
    case (drv_mode)
      0: begin mem_rd_gnt = 1'b1; ready_i = 1'b1; end
      1: begin mem_rd_gnt = ($urandom_range(0, 3) != 0); ready_i = ($urandom_range(0, 2) != 0); end
      default: begin mem_rd_gnt = gnt_f; ready_i = rdy_f; end
    endcase
  endtask

  task automatic monitor_step();
    cyc++;
    if (!rst) begin
      prev_so = 1'b0;
      prev_sr = 1'b0;
    end else begin
      if (prev_so) begin
        check("hold valid_o", 128'(valid_o), 128'(1));
        check("hold data_o", data_o, prev_data);
      end
      if (prev_sr) begin
        check("hold mem_rd_req", 128'(mem_rd_req), 128'(1));
        check("hold mem_rd_addr", 128'(mem_rd_addr), 128'(prev_addr));
      end
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (valid_o && first_v < 0) first_v = cyc;
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (mem_rd_req) req_seen++;
      if (mem_rd_req && mem_rd_gnt) rd_q.push_back(int'(mem_rd_addr));
      if (valid_o && !ready_i) stall_o++;
      if (mem_rd_req && !mem_rd_gnt) stall_r++;
      prev_so   = valid_o && !ready_i;
      prev_data = data_o;
      prev_sr   = mem_rd_req && !mem_rd_gnt;
      prev_addr = mem_rd_addr;
    end
  endtask

  // Reference: walk the ledger by the command rules, listing reads and words.
  task automatic build_expect(input bit op, input logic [47:0] id, input int cnt);
    int n;
    bit hit;
    n   = (cnt > MEM_DEPTH) ? MEM_DEPTH : cnt;
    hit = 1'b0;
    exp_q.delete();
    exp_rd.delete();
    for (int i = 0; i < n && !hit; i++) begin
      exp_rd.push_back(i);
      if (!op) exp_q.push_back({8'hA1, 16'(i), 32'h0, mem[i]});
      else if (mem[i][71:24] == id) begin
        exp_q.push_back({8'hA2, 16'(i), 32'h0, mem[i]});
        hit = 1'b1;
      end
    end
    if (!op) exp_q.push_back({8'hAF, 16'(n), 104'h0});
    else if (!hit) exp_q.push_back({8'hAE, 16'(n), 32'h0, id, 24'h0});
  endtask

  task automatic start_cmd(input bit op, input logic [47:0] id, input int cnt);
    bit accepted;
    accepted = 1'b0;
    build_expect(op, id, cnt);
    got_q.delete(); rd_q.delete();
    acc_cyc = -1; first_v = -1; req_seen = 0; stall_o = 0; stall_r = 0;
    @(posedge clk); #1;
    cmd_op = op; cmd_id = id; entry_count = (AW+1)'(cnt); cmd_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (cmd_ready) begin accepted = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_id      = 48'({$urandom(), $urandom()});
    entry_count = (AW+1)'($urandom());
    if (!accepted) check("accept timeout", 128'(0), 128'(1));
  endtask

  task automatic finish_cmd(input string name, input int cnt);
    int budget;
    int m;
    budget = 20 * ((cnt > MEM_DEPTH) ? MEM_DEPTH : cnt) + 400;
    repeat (budget) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size()) break;
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    check({name, " words"}, 128'(got_q.size()), 128'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("%s word%0d", name, i), got_q[i], exp_q[i]);
    check({name, " reads"}, 128'(rd_q.size()), 128'(exp_rd.size()));
    m = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < m; i++) check($sformatf("%s addr%0d", name, i), 128'(rd_q[i]), 128'(exp_rd[i]));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " valid_o"}, 128'(valid_o), 128'(0));
    check({name, " data_o"}, data_o, 128'(0));
    check({name, " mem_rd_req"}, 128'(mem_rd_req), 128'(0));
    check({name, " mem_rd_addr"}, 128'(mem_rd_addr), 128'(0));
    check({name, " cmd_ready"}, 128'(cmd_ready), 128'(0));
  endtask

  initial begin
    fork
      forever begin @(posedge clk); #2; drive_step(); end
      forever begin @(negedge clk); monitor_step(); end
    join_none

    // Reset state and cmd_ready release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("cmd_ready before first edge", 128'(cmd_ready), 128'(0));
    @(negedge clk);
    check("cmd_ready after reset", 128'(cmd_ready), 128'(1));

    // Directed ledger of three entries
    mem[0] = {48'd1, 24'd100};
    mem[1] = {48'd2, 24'd50};
    mem[2] = {48'd3, 24'd0};
    start_cmd(1'b0, 48'd0, 3);
    finish_cmd("dump3", 3);
    check("first valid latency", 128'(first_v - acc_cyc), 128'(3));

    start_cmd(1'b0, 48'd0, 0);
    finish_cmd("dump0", 0);
    check("dump0 no request", 128'(req_seen), 128'(0));

    start_cmd(1'b1, 48'd2, 3);
    finish_cmd("lookup hit", 3);
    start_cmd(1'b1, 48'd7, 3);
    finish_cmd("lookup miss", 3);

    // Backpressure on both the output stream and the read grant
    drv_mode = 2; gnt_f = 1'b1; rdy_f = 1'b0;
    start_cmd(1'b0, 48'd0, 3);
    repeat (50) begin @(negedge clk); if (valid_o) break; end
    repeat (5) @(negedge clk);
    @(posedge clk); #1; rdy_f = 1'b1; gnt_f = 1'b0;
    repeat (6) @(posedge clk);
    #1; gnt_f = 1'b1;
    finish_cmd("backpressure", 3);
    check("output stall seen", 128'(stall_o >= 5), 128'(1));
    check("grant stall seen", 128'(stall_r >= 4), 128'(1));

    // Randomized commands over small ledgers with duplicate ids
    drv_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) mem[i] = {48'($urandom_range(1, 6)), 24'($urandom())};
      start_cmd(1'($urandom_range(0, 1)), 48'($urandom_range(1, 7)), n);
      finish_cmd($sformatf("rand%0d", t), n);
    end

    // entry_count beyond depth: full-ledger miss reports index MEM_DEPTH
    drv_mode = 0;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = {1'b1, 47'($urandom()), 24'($urandom())};
    start_cmd(1'b1, 48'd5, 20000);
    finish_cmd("full miss", 20000);

    // Reset mid-dump aborts, next dump restarts at index 0
    drv_mode = 1;
    for (int i = 0; i < 10; i++) mem[i] = {48'($urandom_range(1, 6)), 24'($urandom())};
    start_cmd(1'b0, 48'd0, 10);
    repeat (12) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid reset");
    start_cmd(1'b0, 48'd0, 10);
    finish_cmd("after reset", 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ledger_reader.md
# ledger_reader

Read-side companion to the transaction validator's account ledger. On command it scans the shared ledger RAM (72-bit entries: id[71:24], balance[23:0]) through an arbitrated read port. It either dumps every populated entry or looks up one account id. Results leave as 128-bit words on a valid/ready stream toward the host-side output path.

## Interface
Parameters:
- MEM_WIDTH, 72, ledger entry width (id 48 + balance 24)
- MEM_DEPTH, 16384, ledger depth; address width AW = $clog2(MEM_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0 = dump all, 1 = lookup by id
- cmd_id  in  48  account id for lookup; ignored for dump
- entry_count  in  AW+1  number of populated ledger entries (validator's counter)
- mem_rd_req  out  1  read request to ledger arbiter
- mem_rd_gnt  in  1  arbiter grant, same cycle as req
- mem_rd_addr  out  AW  read address, valid with mem_rd_req
- mem_rd_data  in  MEM_WIDTH  read data, valid exactly 1 cycle after a granted req
- data_o  out  128  result word
- valid_o  out  1  result valid
- ready_i  in  1  downstream ready

## Operation
- Output word: [127:120] tag, [119:104] index (zero-extended), [103:72] zero, [71:0] ledger entry or {cmd_id, 24'h0}.
- Tags: 8'hA1 dump record, 8'hAF dump end, 8'hA2 lookup hit, 8'hAE lookup miss.
- FSM states: IDLE, RD_REQ, RD_WAIT, EMIT, DONE.
- IDLE: cmd_ready=1. On accept, latch op, id, and n = min(entry_count, MEM_DEPTH); idx=0. If n==0, go to DONE; else go to RD_REQ.
- RD_REQ: mem_rd_req=1, mem_rd_addr=idx. Advance to RD_WAIT on gnt; hold req and addr otherwise.
- RD_WAIT: capture mem_rd_data.
  - Dump: go to EMIT with tag A1.
  - Lookup, id match: go to EMIT with tag A2.
  - Lookup, no match: idx++. If idx==n, go to DONE; else go to RD_REQ.
- EMIT: valid_o=1 and wait for ready_i.
  - Dump: idx++, then go to DONE if idx==n, else RD_REQ.
  - Lookup hit: go to IDLE.
- DONE: emit one terminator and wait for ready_i, then go to IDLE.
  - Dump: tag AF, index=n, entry field zero.
  - Lookup: tag AE, index=n, entry={cmd_id, 24'h0}.
- Lookup stops at the first match; later duplicates are not reported.
- entry_count changes after accept are ignored. Ledger writes during a scan are not coherent; the arbiter owner is responsible for that.
- No commands are accepted outside IDLE.

## Timing
- Reset values: valid_o=0, data_o=0, mem_rd_req=0, mem_rd_addr=0, cmd_ready=0. cmd_ready rises the first cycle after rst goes high; state=IDLE.
- All outputs are registered except mem_rd_req/mem_rd_addr, which decode from state and idx.
- With constant gnt and ready_i:
  - Command accepted at cycle N, first mem_rd_req at N+1, data at N+2, valid_o at N+3.
  - One record every 3 cycles.
- Stall: while valid_o & !ready_i, data_o and valid_o are held bit-stable. Likewise, mem_rd_addr is held while req & !gnt.
- Index arithmetic is AW+1 bits, so idx==MEM_DEPTH never wraps to 0.
- Reset mid-scan aborts at once. The following cycle shows reset values with no partial word or request.

## Structure
- Shared package ledger_pkg:
  - MEM_WIDTH, MEM_DEPTH, the ID_W=48 / BAL_W=24 field slices, tag constants, and the FSM state enum.
  - The validator imports the same package.
- One natural sub-module: ledger_out_reg, a single-entry valid/ready output register holding data_o/valid_o. The FSM pushes into it and waits for it to be empty.

## Test plan
- Dump, entry_count=3, entries {id 1, 100}, {id 2, 50}, {id 3, 0}, ready_i=1, gnt=1 -> three A1 words with index 0,1,2 and matching entries, then AF with index 3. First valid_o 3 cycles after accept.
- Dump with entry_count=0 -> a single AF word with index 0 and no mem_rd_req asserted.
- Lookup of id 2 in the ledger above -> one A2 word with index 1 and entry {2, 50}. Addresses 0 and 1 are read; address 2 is never read.
- Lookup of id 7 -> AE word with index 3 and entry {7, 0}, after reads of addresses 0..2.
- Backpressure: ready_i low for 5 cycles during a dump, plus gnt low for 4 cycles on one request -> data_o/valid_o and mem_rd_addr stay constant, and no record is lost or duplicated.
- rst low for 1 cycle mid-dump -> all outputs take reset values. A new dump afterward restarts at index 0.
